// File: rtl/trap_ctrl_pkg.sv
// trap_ctrl_pkg: CSR widths, addresses, cause codes, mstatus fields and FSM states for trap_ctrl
package trap_ctrl_pkg;
  localparam int CSR_WIDTH = 64;
  localparam int CSR_ADDR_WIDTH = 12;
  localparam int INSTR_MEM_WIDTH = 32;
  localparam logic [CSR_ADDR_WIDTH-1:0] CSR_MSTATUS = 12'h300;
  localparam logic [CSR_ADDR_WIDTH-1:0] CSR_MTVEC = 12'h305;
  localparam logic [CSR_ADDR_WIDTH-1:0] CSR_MEPC = 12'h341;
  localparam logic [CSR_ADDR_WIDTH-1:0] CSR_MCAUSE = 12'h342;
  localparam logic [CSR_WIDTH-1:0] CAUSE_ILLEGAL = 64'd2;
  localparam logic [CSR_WIDTH-1:0] CAUSE_ECALL_M = 64'd11;
  localparam logic [CSR_WIDTH-1:0] CAUSE_IRQ_EXT_M = {1'b1, 59'd0, 4'd11};
  localparam int MSTATUS_MIE = 3;
  localparam int MSTATUS_MPIE = 7;
  localparam int MSTATUS_MPP_LO = 11;
  localparam int MSTATUS_MPP_HI = 12;
  typedef enum logic [2:0] {
    IDLE, T_EPC, T_CAUSE, T_STATUS, T_REDIR, R_STATUS, R_REDIR
  } state_t;
  function automatic logic [CSR_WIDTH-1:0] trap_status(input logic [CSR_WIDTH-1:0] s);
    logic [CSR_WIDTH-1:0] r;
    r = s;
    r[MSTATUS_MPIE] = s[MSTATUS_MIE];
    r[MSTATUS_MIE] = 1'b0;
    r[MSTATUS_MPP_HI:MSTATUS_MPP_LO] = 2'b11;
    return r;
  endfunction
  function automatic logic [CSR_WIDTH-1:0] mret_status(input logic [CSR_WIDTH-1:0] s);
    logic [CSR_WIDTH-1:0] r;
    r = s;
    r[MSTATUS_MIE] = s[MSTATUS_MPIE];
    r[MSTATUS_MPIE] = 1'b1;
    r[MSTATUS_MPP_HI:MSTATUS_MPP_LO] = 2'b00;
    return r;
  endfunction
endpackage

// File: rtl/trap_ctrl.sv
// trap_ctrl: trap-entry/mret sequencer and CSR port arbiter; TRAP_CTRL_IRQ_EN adds the external interrupt path
module trap_ctrl
  import trap_ctrl_pkg::*;
(
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       ecall_i,
  input  logic                       illegal_i,
  input  logic                       mret_i,
`ifdef TRAP_CTRL_IRQ_EN
  input  logic                       irq_i,
`endif
  input  logic [INSTR_MEM_WIDTH-1:0] pc_i,
  input  logic                       cpu_csr_we,
  input  logic [CSR_ADDR_WIDTH-1:0]  cpu_csr_waddr,
  input  logic [CSR_WIDTH-1:0]       cpu_csr_wdata,
  input  logic [CSR_ADDR_WIDTH-1:0]  cpu_csr_raddr,
  output logic [CSR_WIDTH-1:0]       cpu_csr_rdata,
  output logic                       csr_we,
  output logic [CSR_ADDR_WIDTH-1:0]  csr_waddr,
  output logic [CSR_WIDTH-1:0]       csr_wdata,
  output logic [CSR_ADDR_WIDTH-1:0]  csr_raddr,
  input  logic [CSR_WIDTH-1:0]       csr_rdata,
  output logic                       stall_o,
  output logic                       redirect_valid_o,
  output logic [INSTR_MEM_WIDTH-1:0] redirect_pc_o
);
  state_t state, state_n;
  logic [INSTR_MEM_WIDTH-1:0] pc_q;
  logic [CSR_WIDTH-1:0] cause_q, cause_n;
  logic idle, irq_evt, trap_evt, any_evt;
`ifdef TRAP_CTRL_IRQ_EN
  logic mie_q;
  assign irq_evt = irq_i & mie_q;
  // Shadow of mstatus.MIE, tracked from every write this block issues to mstatus
  always_ff @(posedge clk or posedge rst)
    if (rst) mie_q <= 1'b0;
    else if (csr_we && csr_waddr == CSR_MSTATUS) mie_q <= csr_wdata[MSTATUS_MIE];
`else
  assign irq_evt = 1'b0;
`endif
  assign idle = state == IDLE;
  assign trap_evt = illegal_i | ecall_i | (irq_evt & ~mret_i);
  assign any_evt = illegal_i | ecall_i | mret_i | irq_evt;
  assign cause_n = illegal_i ? CAUSE_ILLEGAL : ecall_i ? CAUSE_ECALL_M : CAUSE_IRQ_EXT_M;
  // State, trapping PC and cause registers
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= IDLE;
      pc_q <= '0;
      cause_q <= '0;
    end else begin
      state <= state_n;
      if (idle && trap_evt) begin
        pc_q <= pc_i;
        cause_q <= cause_n;
      end
    end
  // Next-state sequencing; events are only looked at in IDLE
  always_comb begin
    state_n = state;
    case (state)
      IDLE:     state_n = trap_evt ? T_EPC : mret_i ? R_STATUS : IDLE;
      T_EPC:    state_n = T_CAUSE;
      T_CAUSE:  state_n = T_STATUS;
      T_STATUS: state_n = T_REDIR;
      R_STATUS: state_n = R_REDIR;
      default:  state_n = IDLE;
    endcase
  end
  // CSR port mux, stall and redirect; everything held at zero during reset
  always_comb begin
    csr_we = 1'b0;
    csr_waddr = '0;
    csr_wdata = '0;
    csr_raddr = '0;
    cpu_csr_rdata = '0;
    stall_o = 1'b0;
    redirect_valid_o = 1'b0;
    redirect_pc_o = '0;
    if (!rst)
      case (state)
        IDLE: begin
          csr_we = cpu_csr_we & ~any_evt;
          csr_waddr = cpu_csr_waddr;
          csr_wdata = cpu_csr_wdata;
          csr_raddr = cpu_csr_raddr;
          cpu_csr_rdata = csr_rdata;
          stall_o = any_evt;
        end
        T_EPC: begin
          csr_we = 1'b1;
          csr_waddr = CSR_MEPC;
          csr_wdata = CSR_WIDTH'(pc_q);
          stall_o = 1'b1;
        end
        T_CAUSE: begin
          csr_we = 1'b1;
          csr_waddr = CSR_MCAUSE;
          csr_wdata = cause_q;
          stall_o = 1'b1;
        end
        T_STATUS, R_STATUS: begin
          csr_raddr = CSR_MSTATUS;
          csr_we = 1'b1;
          csr_waddr = CSR_MSTATUS;
          csr_wdata = state == T_STATUS ? trap_status(csr_rdata) : mret_status(csr_rdata);
          stall_o = 1'b1;
        end
        T_REDIR, R_REDIR: begin
          csr_raddr = state == T_REDIR ? CSR_MTVEC : CSR_MEPC;
          redirect_valid_o = 1'b1;
          redirect_pc_o = {csr_rdata[INSTR_MEM_WIDTH-1:2], 2'b00};
        end
        default: ;
      endcase
  end
endmodule
